// File: rtl/uart_ram_pkg.sv
// Shared constants and read-FSM encoding for the UART RAM queue ports.
package uart_ram_pkg;

    localparam int RAM_HALF_ADDR_W = 8;
    localparam int DATA_W          = 8;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_HOLD = 2'd2;

endpackage

// File: rtl/uart_stage_fifo.sv
// Small synchronous FIFO staging RX bytes before they are written to the ring.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_stage_fifo
    import uart_ram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_ram_queue_port.sv
// One device port of the shared UART RAM: RX bytes go out as a ring queue in
// our write half, the peer's ring is read from our read half toward TX.
//
//   state  | meaning
//   R_IDLE | no read in flight; start one when the peer ring has data and TX is free
//   R_REQ  | o_re held high until an ack that belongs to this request arrives
//   R_HOLD | byte presented on o_tx_data, waiting for i_tx_ready
module uart_ram_queue_port
    import uart_ram_pkg::*;
#(
    parameter int ADDR_W      = RAM_HALF_ADDR_W,
    parameter int STAGE_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [ADDR_W-1:0] o_r_addr,
    output logic              o_re,
    input  logic [DATA_W-1:0] i_r_data,
    input  logic              i_ack_r,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_we,
    input  logic              i_ack_w,
    output logic [ADDR_W-1:0] o_w_ptr,
    output logic [ADDR_W-1:0] o_r_ptr,
    input  logic [ADDR_W-1:0] i_peer_w_ptr,
    input  logic [ADDR_W-1:0] i_peer_r_ptr,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);

    logic [ADDR_W-1:0] w_ptr_q, r_ptr_q;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [1:0]        state_q, state_d;
    logic              re_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              ovf_q;
    logic              capture;
    logic              rd_avail;
    logic              wr_space;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              w_done;
    logic              rx_drop;

    assign w_ptr_inc = w_ptr_q + ADDR_W'(1);
    assign rd_avail  = (r_ptr_q != i_peer_w_ptr);
    assign wr_space  = (w_ptr_inc != i_peer_r_ptr);

    assign o_we    = !fifo_empty && wr_space;
    assign w_done  = o_we && i_ack_w;
    assign rx_drop = i_rx_valid && fifo_full && !w_done;

    uart_stage_fifo #(
        .DEPTH (STAGE_DEPTH)
    ) u_stage (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .push_i  (i_rx_valid),
        .data_i  (i_rx_data),
        .pop_i   (w_done),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign o_w_addr   = w_ptr_q;
    assign o_w_data   = o_we ? fifo_head : '0;
    assign o_w_ptr    = w_ptr_q;
    assign o_r_ptr    = r_ptr_q;
    assign o_r_addr   = r_ptr_q;
    assign o_re       = (state_q == R_REQ);
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_overflow = ovf_q;

    // re_q filters out the ack answering a request from a previous visit to R_REQ.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (rd_avail && !tx_valid_q) begin
                    state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (i_ack_r && re_q) begin
                    capture = 1'b1;
                    state_d = R_HOLD;
                end
            end
            R_HOLD: begin
                if (i_tx_ready) begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= R_IDLE;
            re_q       <= 1'b0;
            r_ptr_q    <= '0;
            w_ptr_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q    <= o_re;
            if (capture) begin
                tx_data_q  <= i_r_data;
                tx_valid_q <= 1'b1;
                r_ptr_q    <= r_ptr_q + ADDR_W'(1);
            end else if (state_q == R_HOLD && i_tx_ready) begin
                tx_valid_q <= 1'b0;
            end
            if (w_done) begin
                w_ptr_q <= w_ptr_inc;
            end
            if (rx_drop) begin
                ovf_q <= 1'b1;
            end else if (i_clr_overflow) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_ram_queue_port.sv
// Directed bench for uart_ram_queue_port with a small registered-ack read mux model.
module tb_uart_ram_queue_port;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic [7:0] o_r_addr;
    logic       o_re;
    logic [7:0] i_r_data;
    logic       i_ack_r;
    logic [7:0] o_w_addr;
    logic [7:0] o_w_data;
    logic       o_we;
    logic       i_ack_w;
    logic [7:0] o_w_ptr;
    logic [7:0] o_r_ptr;
    logic [7:0] i_peer_w_ptr;
    logic [7:0] i_peer_r_ptr;
    logic       o_overflow;
    logic       i_clr_overflow;

    logic [7:0] rmem [256];
    logic       ack_en;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 i_clk = ~i_clk;

    uart_ram_queue_port #(.ADDR_W(8), .STAGE_DEPTH(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_r_addr       (o_r_addr),
        .o_re           (o_re),
        .i_r_data       (i_r_data),
        .i_ack_r        (i_ack_r),
        .o_w_addr       (o_w_addr),
        .o_w_data       (o_w_data),
        .o_we           (o_we),
        .i_ack_w        (i_ack_w),
        .o_w_ptr        (o_w_ptr),
        .o_r_ptr        (o_r_ptr),
        .i_peer_w_ptr   (i_peer_w_ptr),
        .i_peer_r_ptr   (i_peer_r_ptr),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    // Read side of the mux: ack and data registered one cycle after the request.
    always @(posedge i_clk) begin
        i_ack_r  <= o_re && ack_en;
        i_r_data <= rmem[o_r_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] d);
        i_rx_data  = d;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = 8'(i) ^ 8'hA5;
        rmem[8'h00] = 8'hC3;
        rmem[8'h01] = 8'h7E;
        rmem[8'hFF] = 8'h3C;
        i_ack_r = 1'b0;
        i_r_data = 8'h00;
        i_rst_n = 1'b0;
        i_rx_data = 8'h00;
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b0;
        i_ack_w = 1'b0;
        i_peer_w_ptr = 8'h00;
        i_peer_r_ptr = 8'h00;
        i_clr_overflow = 1'b0;
        ack_en = 1'b1;
        tick();
        tick();
        check("reset_ctl", {o_we, o_re, o_tx_valid, o_overflow}, 4'b0000);
        check("reset_ptrs", {o_w_ptr, o_r_ptr, o_tx_data}, 24'h0);
        i_rst_n = 1'b1;
        tick();

        // single write with ack tied high
        i_ack_w = 1'b1;
        rx_byte(8'h5A);
        check("wr1_req", {o_we, o_w_addr, o_w_data}, {1'b1, 8'h00, 8'h5A});
        tick();
        check("wr1_done", {o_we, o_w_ptr}, {1'b0, 8'h01});

        // ack withheld for 5 cycles
        i_ack_w = 1'b0;
        rx_byte(8'h11);
        for (int i = 0; i < 5; i++) begin
            check("wr_hold", {o_we, o_w_addr, o_w_data}, {1'b1, 8'h01, 8'h11});
            tick();
        end
        i_ack_w = 1'b1;
        check("wr_hold6", {o_we, o_w_addr, o_w_data}, {1'b1, 8'h01, 8'h11});
        tick();
        check("wr_ack_once", {o_we, o_w_ptr}, {1'b0, 8'h02});

        // stream until the ring is full at w_ptr 0xFE
        i_peer_r_ptr = 8'hFF;
        for (int i = 0; i < 252; i++) rx_byte(8'(i));
        tick();
        tick();
        tick();
        check("ring_full_ptr", {o_we, o_w_ptr}, {1'b0, 8'hFE});
        rx_byte(8'hA0);
        rx_byte(8'hA1);
        rx_byte(8'hA2);
        rx_byte(8'hA3);
        check("stage4_no_ovf", {o_we, o_overflow}, 2'b00);
        rx_byte(8'hA4);
        check("ovf_set", o_overflow, 1'b1);
        check("ovf_ptr_hold", o_w_ptr, 8'hFE);
        i_clr_overflow = 1'b1;
        tick();
        check("ovf_clr", o_overflow, 1'b0);
        i_rx_data = 8'hA5;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        check("ovf_set_wins", o_overflow, 1'b1);
        tick();
        i_clr_overflow = 1'b0;
        check("ovf_clr2", o_overflow, 1'b0);

        // open one slot: push and pop in the same cycle while full
        i_peer_r_ptr = 8'h00;
        #1;
        check("full_pp_req", {o_we, o_w_addr, o_w_data}, {1'b1, 8'hFE, 8'hA0});
        rx_byte(8'hB0);
        check("full_pp_no_ovf", o_overflow, 1'b0);
        check("full_pp_ptr", {o_we, o_w_ptr}, {1'b0, 8'hFF});
        i_peer_r_ptr = 8'h10;
        #1;
        check("wrap_wr_data", {o_we, o_w_addr, o_w_data}, {1'b1, 8'hFF, 8'hA1});
        for (int i = 0; i < 5; i++) tick();
        check("wrap_wr_ptr", {o_we, o_w_ptr}, {1'b0, 8'h03});

        // first read: 0xC3 from address 0
        i_peer_w_ptr = 8'h01;
        tick();
        check("rd1_req", {o_re, o_r_addr}, {1'b1, 8'h00});
        tick();
        check("rd1_wait", o_tx_valid, 1'b0);
        tick();
        check("rd1_cap", {o_tx_valid, o_tx_data, o_r_ptr, o_re}, {1'b1, 8'hC3, 8'h01, 1'b0});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd1_hold", {o_tx_valid, o_re, o_r_ptr}, {1'b1, 1'b0, 8'h01});
        end
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        check("rd1_release", o_tx_valid, 1'b0);

        // ack withheld four cycles
        ack_en = 1'b0;
        i_peer_w_ptr = 8'h02;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rd_wait_steady", {o_re, o_r_addr}, {1'b1, 8'h01});
            tick();
        end
        ack_en = 1'b1;
        tick();
        tick();
        check("rd2_cap", {o_tx_valid, o_tx_data, o_r_ptr}, {1'b1, 8'h7E, 8'h02});
        tick();
        check("stray_ack", {o_tx_valid, o_r_ptr, o_re}, {1'b1, 8'h02, 1'b0});
        i_tx_ready = 1'b1;
        tick();

        // drain reads up to r_ptr 0xFF with TX always ready
        i_peer_w_ptr = 8'hFF;
        for (int k = 0; k < 3000 && !(o_r_ptr == 8'hFF && !o_tx_valid); k++) tick();
        check("rd_drain_ptr", {o_r_ptr, o_tx_valid}, {8'hFF, 1'b0});
        check("rd_drain_last", o_tx_data, 8'h5B);
        i_tx_ready = 1'b0;

        // reads across the wrap: 0xFF then 0x00
        i_peer_w_ptr = 8'h01;
        tick();
        check("wrap_rd_addr0", {o_re, o_r_addr}, {1'b1, 8'hFF});
        tick();
        tick();
        check("wrap_rd_cap0", {o_tx_valid, o_tx_data, o_r_ptr}, {1'b1, 8'h3C, 8'h00});
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        tick();
        check("wrap_rd_addr1", {o_re, o_r_addr}, {1'b1, 8'h00});
        tick();
        tick();
        check("wrap_rd_cap1", {o_tx_valid, o_tx_data, o_r_ptr}, {1'b1, 8'hC3, 8'h01});
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;

        // reset while a read and a write are both pending
        i_ack_w = 1'b0;
        rx_byte(8'h99);
        i_peer_w_ptr = 8'h02;
        tick();
        check("pre_rst", {o_re, o_we}, 2'b11);
        i_rst_n = 1'b0;
        tick();
        check("mid_rst_ctl", {o_we, o_re, o_tx_valid, o_overflow}, 4'b0000);
        check("mid_rst_data", {o_w_ptr, o_r_ptr, o_w_addr, o_r_addr, o_w_data, o_tx_data}, 48'h0);
        i_peer_w_ptr = 8'h00;
        i_peer_r_ptr = 8'h00;
        i_ack_w = 1'b1;
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();
        check("post_rst", {o_r_ptr, o_w_ptr, o_tx_valid, o_re}, 18'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
